// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Holds op codes, FSM states, counter sizing and sign-magnitude helper.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    // Widest product the negation helper supports (WIDTH up to 64).
    localparam int MAX_W = 128;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(MD_WIDTH);

    // Conditional two's-complement negation. Callers zero-extend into
    // MAX_W bits and truncate the result back to their own width; the
    // low bits are identical to a native-width negation.
    function automatic logic [MAX_W-1:0] neg_if(
        input logic [MAX_W-1:0] v,
        input logic             s
    );
        return s ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; one bit per clock.
// Ports: clk, reset, start/op/op1/op2 in; busy, done, div_by_zero, hi, lo out.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_w(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sgn_q, sgn_d;
    logic               rsgn_q, rsgn_d;
    logic               isdiv_q, isdiv_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    op_t                op_e;
    logic               signed_op;
    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_e      = op_t'(op);
    assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign op1_neg   = signed_op & op1[WIDTH-1];
    assign op2_neg   = signed_op & op2[WIDTH-1];
    assign op1_mag   = WIDTH'(neg_if(MAX_W'(op1), op1_neg));
    assign op2_mag   = WIDTH'(neg_if(MAX_W'(op2), op2_neg));

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // The carry out of the add lands in the top bit after the shift.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, dsr_q} : '0);

    // Divide: acc = {remainder, dividend/quotient}. Borrow means restore.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, dsr_q};

    assign prod_fix = (2*WIDTH)'(neg_if(MAX_W'(acc_q), sgn_q));
    assign quo_fix  = WIDTH'(neg_if(MAX_W'(acc_q[WIDTH-1:0]), sgn_q));
    assign rem_fix  = WIDTH'(neg_if(MAX_W'(acc_q[2*WIDTH-1:WIDTH]), rsgn_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dsr_d   = dsr_q;
        acc_d   = acc_q;
        sgn_d   = sgn_q;
        rsgn_d  = rsgn_q;
        isdiv_d = isdiv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op_e)
                        OP_MULT, OP_MULTU: begin
                            dsr_d   = op1_mag;
                            acc_d   = {{WIDTH{1'b0}}, op2_mag};
                            sgn_d   = op1_neg ^ op2_neg;
                            rsgn_d  = 1'b0;
                            isdiv_d = 1'b0;
                            cnt_d   = CW'(WIDTH);
                            state_d = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (op2 == '0) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                dsr_d   = op2_mag;
                                acc_d   = {{WIDTH{1'b0}}, op1_mag};
                                sgn_d   = op1_neg ^ op2_neg;
                                rsgn_d  = op1_neg;
                                isdiv_d = 1'b1;
                                cnt_d   = CW'(WIDTH);
                                state_d = DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = op1;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = op1;
                            done_d = 1'b1;
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            DIV: begin
                if (rem_diff[WIDTH]) begin
                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isdiv_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dsr_q   <= '0;
            acc_q   <= '0;
            sgn_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            isdiv_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dsr_q   <= dsr_d;
            acc_q   <= acc_d;
            sgn_q   <= sgn_d;
            rsgn_q  <= rsgn_d;
            isdiv_q <= isdiv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Drives and samples on the falling edge; results checked by assertions.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    int cyc;
    int bc;
    logic dz;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .op1         (op1),
        .op2         (op2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge. Issues start this cycle, then follows
    // the unit until done (bounded). cyc = cycles after start to done,
    // bc = cycles with busy high. inj>0 pulses a DIV start at that cycle.
    task automatic run_op(input op_t o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inj);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        cyc   = 0;
        bc    = 0;
        dz    = 1'b0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (inj > 0 && cyc == inj) begin
                start = 1'b1;
                op    = OP_DIV;
                op1   = 32'd100;
                op2   = 32'd7;
            end
            if (inj > 0 && cyc == inj + 1) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                dz = div_by_zero;
                break;
            end
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        op1   = '0;
        op2   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_cyc", cyc, 34);
        chk("mult_busy", bc, 33);
        chk("mult_hi", hi, 64'hFFFF_FFFF);
        chk("mult_lo", lo, 64'hFFFF_FFFA);
        chk("mult_dbz", dz, 0);
        @(negedge clk);
        chk("mult_done_pulse", done, 0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_hi", hi, 64'hFFFF_FFFE);
        chk("multu_lo", lo, 64'h0000_0001);

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mult_m1_hi", hi, 0);
        chk("mult_m1_lo", lo, 1);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_cyc", cyc, 34);
        chk("div_lo", lo, 64'hFFFF_FFFD);
        chk("div_hi", hi, 64'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd7, 32'd2, 0);
        chk("divu_lo", lo, 3);
        chk("divu_hi", hi, 1);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_min_lo", lo, 64'h8000_0000);
        chk("div_min_hi", hi, 0);

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0);
        chk("div_negd_lo", lo, 64'hFFFF_FFFD);
        chk("div_negd_hi", hi, 1);

        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 0);
        chk("divu_big_lo", lo, 64'h0FFF_FFFF);
        chk("divu_big_hi", hi, 64'hF);

        run_op(OP_MTHI, 32'h1234, 32'd0, 0);
        chk("mthi_cyc", cyc, 1);
        chk("mthi_busy", bc, 0);
        chk("mthi_hi", hi, 64'h1234);
        run_op(OP_MTLO, 32'h5678, 32'd0, 0);
        chk("mtlo_lo", lo, 64'h5678);
        chk("mtlo_hi_kept", hi, 64'h1234);
        @(negedge clk);
        chk("mtlo_done_pulse", done, 0);

        run_op(OP_DIV, 32'd99, 32'd0, 0);
        chk("dbz_cyc", cyc, 1);
        chk("dbz_flag", dz, 1);
        chk("dbz_busy", bc, 0);
        chk("dbz_hi", hi, 64'h1234);
        chk("dbz_lo", lo, 64'h5678);
        @(negedge clk);
        chk("dbz_pulse", div_by_zero, 0);

        run_op(OP_NOP6, 32'hDEAD, 32'hBEEF, 0);
        chk("nop_cyc", cyc, 1);
        chk("nop_dbz", dz, 0);
        chk("nop_hi", hi, 64'h1234);
        chk("nop_lo", lo, 64'h5678);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5);
        chk("ign_cyc", cyc, 34);
        chk("ign_hi", hi, 64'hFFFF_FFFF);
        chk("ign_lo", lo, 64'hFFFF_FFFA);

        run_op(OP_MULT, 32'hFFFF_FFFA, 32'd7, 0);
        chk("b2b_cyc", cyc, 34);
        chk("b2b_hi", hi, 64'hFFFF_FFFF);
        chk("b2b_lo", lo, 64'hFFFF_FFD6);

        @(negedge clk);
        start = 1'b1;
        op    = OP_DIV;
        op1   = 32'd1000;
        op2   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no_done_after_rst", seen, 0);
        chk("post_rst_lo", lo, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
